// File: rtl/ram_req_responder.sv
// Tagged RAM request responder: in-order request FIFO feeding a sync block RAM.
// Define RAM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses.
module ram_req_responder #(
   parameter int RAM_DEPTH = 700,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int TAG_W     = 8,
   parameter int QDEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   input  logic [TAG_W-1:0]          req_tag,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      rsp_err,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem [RAM_DEPTH] = '{default: '0};

   logic              q_wr   [QDEPTH];
   logic [AW-1:0]     q_idx  [QDEPTH];
   logic [DATA_W-1:0] q_data [QDEPTH];
   logic [TAG_W-1:0]  q_tag  [QDEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          enq;
   logic          head_ok;
   logic          issue_wr;
   logic          issue_rd;
   logic          deq;
   logic          head_oor;
   logic          req_oor;
   logic [AW-1:0] req_idx;

   assign req_idx = req_addr[AW-1:0];

`ifdef RAM_BOUNDS_CHECK_EN
   logic q_oor [QDEPTH];
   logic err_q;

   assign req_oor  = req_addr >= ADDR_W'(RAM_DEPTH);
   assign head_oor = q_oor[rd_ptr];
   assign rsp_err  = err_q;

   always_ff @(posedge clk) begin
      if (enq)
         q_oor[wr_ptr] <= req_oor;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (issue_rd)
         err_q <= head_oor;
   end
`else
   logic unused_addr;

   assign req_oor     = 1'b0;
   assign head_oor    = req_oor;
   assign rsp_err     = 1'b0;
   assign unused_addr = ^req_addr[ADDR_W-1:AW];
`endif

   // Count is registered so req_ready never depends on rsp_ready.
   assign req_ready = q_count < CW'(QDEPTH);
   assign enq       = req_valid && req_ready;
   assign head_ok   = q_count != '0;
   assign issue_wr  = head_ok && q_wr[rd_ptr];
   assign issue_rd  = head_ok && !q_wr[rd_ptr] &&
                      (!rsp_valid || rsp_ready);
   assign deq       = issue_wr || issue_rd;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PW'(1);
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         if (enq && !deq)
            q_count <= q_count + CW'(1);
         else if (!enq && deq)
            q_count <= q_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_wr[wr_ptr]   <= req_write;
         q_idx[wr_ptr]  <= req_idx;
         q_data[wr_ptr] <= req_wdata;
         q_tag[wr_ptr]  <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_wr && !head_oor)
         mem[q_idx[rd_ptr]] <= q_data[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
      end else if (issue_rd) begin
         rsp_valid <= 1'b1;
         rsp_tag   <= q_tag[rd_ptr];
         rsp_data  <= head_oor ? '1 : mem[q_idx[rd_ptr]];
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_req_responder.sv
// Directed bench for ram_req_responder.
// Bounds-check steps run only when RAM_BOUNDS_CHECK_EN is defined.
module tb_ram_req_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [7:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [7:0]  rsp_tag;
   logic        rsp_err;
   logic [2:0]  q_count;

   int checks = 0;
   int errors = 0;

   ram_req_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err),
      .q_count   (q_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic put(input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [7:0] t);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_tag   = t;
   endtask

   task automatic chk_rsp(input string name, input logic [7:0] t,
                          input logic [15:0] d, input logic e);
      chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({name, "_tag"}, {24'b0, rsp_tag}, {24'b0, t});
      chk({name, "_data"}, {16'b0, rsp_data}, {16'b0, d});
      chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, e});
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_count", {29'b0, q_count}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_data", {16'b0, rsp_data}, 32'd0);
      chk("rst_tag", {24'b0, rsp_tag}, 32'd0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);

      // round trip with one-cycle read latency
      rsp_ready = 1'b1;
      put(1'b1, 16'd52, 16'h1210, 8'd0);
      step();
      put(1'b1, 16'd54, 16'h5454, 8'd0);
      step();
      put(1'b0, 16'd52, 16'h0000, 8'd0);
      step();
      req_valid = 1'b0;
      chk("rt_not_yet", {31'b0, rsp_valid}, 32'd0);
      step();
      chk_rsp("rt", 8'd0, 16'h1210, 1'b0);
      step();
      chk("rt_clear", {31'b0, rsp_valid}, 32'd0);

      // back-to-back reads, no bubble
      put(1'b0, 16'd52, 16'h0, 8'd0);
      step();
      put(1'b0, 16'd54, 16'h0, 8'd1);
      step();
      req_valid = 1'b0;
      chk_rsp("b2b0", 8'd0, 16'h1210, 1'b0);
      step();
      chk_rsp("b2b1", 8'd1, 16'h5454, 1'b0);
      step();
      chk("b2b_clear", {31'b0, rsp_valid}, 32'd0);

      // backpressure: 1 held + 4 queued
      rsp_ready = 1'b0;
      put(1'b0, 16'd52, 16'h0, 8'd10);
      step();
      put(1'b0, 16'd54, 16'h0, 8'd11);
      step();
      put(1'b0, 16'd52, 16'h0, 8'd12);
      step();
      put(1'b0, 16'd54, 16'h0, 8'd13);
      step();
      put(1'b0, 16'd52, 16'h0, 8'd14);
      step();
      req_valid = 1'b0;
      chk("bp_count", {29'b0, q_count}, 32'd4);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
      chk_rsp("bp_held", 8'd10, 16'h1210, 1'b0);
      step();
      chk_rsp("bp_stable", 8'd10, 16'h1210, 1'b0);
      chk("bp_count2", {29'b0, q_count}, 32'd4);
      rsp_ready = 1'b1;
      step();
      chk_rsp("bp_r11", 8'd11, 16'h5454, 1'b0);
      chk("bp_count3", {29'b0, q_count}, 32'd3);
      step();
      chk_rsp("bp_r12", 8'd12, 16'h1210, 1'b0);
      step();
      chk_rsp("bp_r13", 8'd13, 16'h5454, 1'b0);
      step();
      chk_rsp("bp_r14", 8'd14, 16'h1210, 1'b0);
      step();
      chk("bp_clear", {31'b0, rsp_valid}, 32'd0);
      chk("bp_empty", {29'b0, q_count}, 32'd0);

      // ordering around a write to the same address
      put(1'b0, 16'd100, 16'h0, 8'd3);
      step();
      put(1'b1, 16'd100, 16'hABCD, 8'd0);
      step();
      chk_rsp("ord_old", 8'd3, 16'h0000, 1'b0);
      put(1'b0, 16'd100, 16'h0, 8'd4);
      step();
      req_valid = 1'b0;
      chk("ord_gap", {31'b0, rsp_valid}, 32'd0);
      step();
      chk_rsp("ord_new", 8'd4, 16'hABCD, 1'b0);
      step();

      // mid-operation reset discards queue and held response
      rsp_ready = 1'b0;
      put(1'b0, 16'd52, 16'h0, 8'd20);
      step();
      put(1'b0, 16'd54, 16'h0, 8'd21);
      step();
      put(1'b0, 16'd100, 16'h0, 8'd22);
      step();
      req_valid = 1'b0;
      chk("mr_pre_count", {29'b0, q_count}, 32'd2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mr_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mr_count", {29'b0, q_count}, 32'd0);
      chk("mr_data", {16'b0, rsp_data}, 32'd0);
      chk("mr_tag", {24'b0, rsp_tag}, 32'd0);
      rsp_ready = 1'b1;
      step();
      step();
      chk("mr_no_stale", {31'b0, rsp_valid}, 32'd0);
      put(1'b0, 16'd100, 16'h0, 8'd5);
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("mr_persist", 8'd5, 16'hABCD, 1'b0);
      step();

`ifdef RAM_BOUNDS_CHECK_EN
      put(1'b0, 16'd700, 16'h0, 8'd9);
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("oob_rd", 8'd9, 16'hFFFF, 1'b1);
      put(1'b1, 16'd800, 16'h1234, 8'd0);
      step();
      put(1'b0, 16'd800, 16'h0, 8'd7);
      step();
      put(1'b0, 16'd699, 16'h0, 8'd8);
      step();
      req_valid = 1'b0;
      chk_rsp("oob_800", 8'd7, 16'hFFFF, 1'b1);
      step();
      chk_rsp("edge_699", 8'd8, 16'h0000, 1'b0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_req_responder.md
# ram_req_responder

Responder end of the tagged RAM request protocol used by the out-of-order core's fetch/read queues. It buffers tagged read/write requests in an in-order FIFO and serves them against an internal synchronous block RAM. It returns each read's data together with the original instruction tag over a valid/ready response channel with backpressure. It sits between the core's read-request queue and physical memory, and replaces direct combinational RAM access.

## Interface
- `RAM_DEPTH`, 700: number of 16-bit RAM words.
- `ADDR_W`, 16: request address width.
- `DATA_W`, 16: data width.
- `TAG_W`, 8: tag width (instruction queue index).
- `QDEPTH`, 4: request FIFO depth (power of two, ≥2).
- `clk` in 1: clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data; ignored for reads.
- `req_tag` in TAG_W: tag echoed on the read response.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out DATA_W: read data.
- `rsp_tag` out TAG_W: tag of the request.
- `rsp_err` out 1: address out of range (see Configuration).
- `q_count` out $clog2(QDEPTH)+1: FIFO occupancy.

## Operation
- Request handshake: an entry is enqueued on an edge where `req_valid && req_ready`.
- `req_ready = (q_count < QDEPTH)`, derived from registered count only. It has no combinational path from `rsp_ready`: when the FIFO is full, `req_ready = 0` even if a dequeue happens in the same cycle.
- FIFO state: circular buffer with wr/rd pointers wrapping modulo QDEPTH. Enqueue and dequeue in the same cycle leave the count unchanged.
- Head processing is strictly in order, at most one entry per cycle:
  - Write head: RAM written at the edge, entry dequeued, no response generated. It is always issuable, even while a response is stalled.
  - Read head: issuable only when `!rsp_valid || rsp_ready`. At the issue edge the RAM is read synchronously into the response register, `rsp_tag` and `rsp_err` are loaded, `rsp_valid` is set, and the entry is dequeued.
  - A read head stalled behind a held response blocks every later entry, including writes, which preserves program order.
- Response handshake:
  - `rsp_valid`, `rsp_data`, `rsp_tag` and `rsp_err` stay stable while `rsp_valid && !rsp_ready`.
  - `rsp_valid` clears on a handshake unless a new read issues on the same edge.
- Ordering: a read behind a write to the same address returns the new data. A read ahead of the write returns the old data.
- RAM is zero-initialised at configuration. Reset never clears the RAM.

## Timing
- Reset (`rst_n = 0` at an edge):
  - `q_count = 0`, pointers = 0.
  - `req_ready = 1` from the next cycle.
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_tag = 0`, `rsp_err = 0`.
- Reset mid-operation: queued requests and any held response are discarded. A write already performed at an earlier edge persists.
- Read latency: a read accepted at edge t with an empty FIFO and idle output issues at edge t+1, so `rsp_valid = 1` from edge t+1.
- Throughput: one request per cycle sustained while `rsp_ready = 1`.
- A write accepted at edge t updates the RAM at edge t+1. A read accepted at edge t+1 sees the new data.

## Configuration
- `RAM_BOUNDS_CHECK_EN` defined:
  - Any `req_addr >= RAM_DEPTH` is out of range.
  - An out-of-range read returns `rsp_data = 16'hFFFF` with `rsp_err = 1`.
  - An out-of-range write is dropped and leaves the RAM unchanged.
  - In-range accesses give `rsp_err = 0`.
- `RAM_BOUNDS_CHECK_EN` undefined:
  - No check logic is generated, and `rsp_err` is tied to 0.
  - Address is used as `req_addr[$clog2(RAM_DEPTH)-1:0]`.
  - Callers must keep addresses < RAM_DEPTH; behaviour for larger addresses is unspecified.

## Test plan
- Reset then basic round trip: write addr 52 = 16'h1210, then read addr 52 tag 0 → `rsp_data = 16'h1210`, `rsp_tag = 0`, `rsp_valid` one cycle after read acceptance.
- Back-to-back reads 52 (tag 0) and 54 (tag 1), `rsp_ready = 1` → two responses on consecutive cycles, tags 0 then 1, no bubble.
- Backpressure: `rsp_ready = 0`, issue 5 reads → 1 held response plus 4 queued, `req_ready = 0`, `q_count = 4`, response stable. Then `rsp_ready = 1` → remaining 4 responses in order.
- Ordering: read 100 (tag 3), write 100 = 16'hABCD, read 100 (tag 4), starting from RAM = 0 → tag 3 returns 0 and tag 4 returns 16'hABCD.
- Mid-operation reset: queue 3 reads under `rsp_ready = 0`, pulse `rst_n = 0` for one edge → `rsp_valid = 0`, `q_count = 0`, and no stale responses appear afterwards.
- With `RAM_BOUNDS_CHECK_EN`: read addr 700 tag 9 → `rsp_data = 16'hFFFF`, `rsp_err = 1`, `rsp_tag = 9`. Write addr 800 followed by a read of addr 800 (RAM_DEPTH − 1 = 699 stays valid) → `rsp_err = 1`; a read of 699 is unaffected.
